// File: rtl/toplu_bellek_aktarici.sv
// Multi-word load/store-multiple engine: moves up to MAKS_SAYI words between register file and memory, one per cycle.
// Optional build macro TOPLU_AKTARIM_HIZA_KONTROL_EN: reject misaligned base addresses instead of aligning them down.
module toplu_bellek_aktarici #(
   parameter  int ADRES_BIT     = 32,
   parameter  int VERI_BIT      = 32,
   parameter  int YAZMAC_SAYISI = 32,
   parameter  int MAKS_SAYI     = 8,
   localparam int YAZMAC_BIT    = $clog2(YAZMAC_SAYISI),
   localparam int SAYI_BIT      = $clog2(MAKS_SAYI + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  baslat,
   input  logic                  yon,
   input  logic [ADRES_BIT-1:0]  taban_adres,
   input  logic [YAZMAC_BIT-1:0] ilk_yazmac,
   input  logic [SAYI_BIT-1:0]   sayi,
   output logic                  mesgul,
   output logic                  bitti,
   output logic                  hata,
   output logic [YAZMAC_BIT-1:0] yazmac_oku_idx,
   input  logic [VERI_BIT-1:0]   yazmac_oku_veri,
   output logic [YAZMAC_BIT-1:0] yazmac_yaz_idx,
   output logic [VERI_BIT-1:0]   yazmac_yaz_veri,
   output logic                  yazmac_yaz,
   output logic [ADRES_BIT-1:0]  bellek_adres,
   input  logic [VERI_BIT-1:0]   bellek_oku_veri,
   output logic [VERI_BIT-1:0]   bellek_yaz_veri,
   output logic                  bellek_yaz
);

   localparam logic [ADRES_BIT-1:0]  ADIM       = ADRES_BIT'(VERI_BIT / 8);
   localparam logic [ADRES_BIT-1:0]  HIZA_MASKE = ADRES_BIT'((VERI_BIT / 8) - 1);
   localparam logic [SAYI_BIT-1:0]   SAYI_MAKS  = SAYI_BIT'(MAKS_SAYI);

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      AKTAR = 2'd1,
      BITTI = 2'd2
   } durum_t;

   durum_t                durum_q, durum_d;
   logic                  yon_q, yon_d;
   logic [ADRES_BIT-1:0]  adres_q, adres_d;
   logic [YAZMAC_BIT-1:0] idx_q, idx_d;
   logic [SAYI_BIT-1:0]   sayi_q, sayi_d;
   logic [SAYI_BIT-1:0]   k_q, k_d;
   logic [SAYI_BIT-1:0]   sinirli_sayi;
   logic                  hizasiz;

   assign sinirli_sayi = (sayi > SAYI_MAKS) ? SAYI_MAKS : sayi;
   assign hizasiz      = |(taban_adres & HIZA_MASKE);

`ifdef TOPLU_AKTARIM_HIZA_KONTROL_EN
   logic hata_q, hata_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) hata_q <= 1'b0;
      else      hata_q <= hata_d;
   end

   always_comb begin
      hata_d = hata_q;
      if (durum_q == BOSTA && baslat) hata_d = hizasiz;
   end

   assign hata = (durum_q == BITTI) && hata_q;
`else
   assign hata = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         durum_q <= BOSTA;
         yon_q   <= 1'b0;
         adres_q <= '0;
         idx_q   <= '0;
         sayi_q  <= '0;
         k_q     <= '0;
      end else begin
         durum_q <= durum_d;
         yon_q   <= yon_d;
         adres_q <= adres_d;
         idx_q   <= idx_d;
         sayi_q  <= sayi_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      durum_d         = durum_q;
      yon_d           = yon_q;
      adres_d         = adres_q;
      idx_d           = idx_q;
      sayi_d          = sayi_q;
      k_d             = k_q;
      mesgul          = 1'b0;
      bitti           = 1'b0;
      yazmac_oku_idx  = '0;
      yazmac_yaz_idx  = '0;
      yazmac_yaz_veri = '0;
      yazmac_yaz      = 1'b0;
      bellek_adres    = '0;
      bellek_yaz_veri = '0;
      bellek_yaz      = 1'b0;

      unique case (durum_q)
         BOSTA: begin
            if (baslat) begin
               yon_d  = yon;
               idx_d  = ilk_yazmac;
               sayi_d = sinirli_sayi;
               k_d    = '0;
`ifdef TOPLU_AKTARIM_HIZA_KONTROL_EN
               adres_d = taban_adres;
               if (hizasiz || sinirli_sayi == '0) durum_d = BITTI;
               else                               durum_d = AKTAR;
`else
               // Misaligned bases are silently rounded down to a word boundary.
               adres_d = taban_adres & ~HIZA_MASKE;
               if (sinirli_sayi == '0) durum_d = BITTI;
               else                    durum_d = AKTAR;
`endif
            end
         end

         AKTAR: begin
            mesgul       = 1'b1;
            bellek_adres = adres_q;
            if (yon_q) begin
               yazmac_oku_idx  = idx_q;
               bellek_yaz_veri = yazmac_oku_veri;
               bellek_yaz      = 1'b1;
            end else begin
               // x0 is hardwired zero: it still uses up a word slot but is never written.
               yazmac_yaz_idx  = idx_q;
               yazmac_yaz_veri = bellek_oku_veri;
               yazmac_yaz      = (idx_q != '0);
            end
            adres_d = adres_q + ADIM;
            idx_d   = idx_q + YAZMAC_BIT'(1);
            k_d     = k_q + SAYI_BIT'(1);
            if (k_q == sayi_q - SAYI_BIT'(1)) durum_d = BITTI;
         end

         BITTI: begin
            bitti   = 1'b1;
            durum_d = BOSTA;
         end

         default: durum_d = BOSTA;
      endcase
   end

endmodule

// File: tb/tb_toplu_bellek_aktarici.sv
// Directed bench for toplu_bellek_aktarici: vector table of transfers plus reset and back-to-back sequences.
module tb_toplu_bellek_aktarici;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        baslat = 1'b0;
   logic        yon = 1'b0;
   logic [31:0] taban_adres = '0;
   logic [4:0]  ilk_yazmac = '0;
   logic [3:0]  sayi = '0;
   logic        mesgul, bitti, hata;
   logic [4:0]  yazmac_oku_idx, yazmac_yaz_idx;
   logic [31:0] yazmac_oku_veri, yazmac_yaz_veri;
   logic        yazmac_yaz;
   logic [31:0] bellek_adres, bellek_oku_veri, bellek_yaz_veri;
   logic        bellek_yaz;
   logic        yukle = 1'b1;

   logic [31:0] rf  [0:31];
   logic [31:0] mem [0:63];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   toplu_bellek_aktarici dut (
      .clk(clk), .rst(rst), .baslat(baslat), .yon(yon), .taban_adres(taban_adres),
      .ilk_yazmac(ilk_yazmac), .sayi(sayi), .mesgul(mesgul), .bitti(bitti), .hata(hata),
      .yazmac_oku_idx(yazmac_oku_idx), .yazmac_oku_veri(yazmac_oku_veri),
      .yazmac_yaz_idx(yazmac_yaz_idx), .yazmac_yaz_veri(yazmac_yaz_veri), .yazmac_yaz(yazmac_yaz),
      .bellek_adres(bellek_adres), .bellek_oku_veri(bellek_oku_veri),
      .bellek_yaz_veri(bellek_yaz_veri), .bellek_yaz(bellek_yaz)
   );

   // Register file and a 64-word memory window; the bench never protects x0 itself.
   assign yazmac_oku_veri = rf[yazmac_oku_idx];
   assign bellek_oku_veri = mem[bellek_adres[7:2]];

   always @(posedge clk) begin
      if (yukle) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         rf[5] <= 32'd5; rf[6] <= 32'd10; rf[7] <= 32'd15; rf[8] <= 32'd12; rf[9] <= 32'd11;
         for (int i = 20; i < 25; i++) rf[i] <= 32'h100 + 32'(i);
         mem[12] <= 32'd5; mem[13] <= 32'd10; mem[14] <= 32'd15; mem[15] <= 32'd25;
         mem[40] <= 32'hDEAD;
      end else begin
         if (bellek_yaz) mem[bellek_adres[7:2]] <= bellek_yaz_veri;
         if (yazmac_yaz) rf[yazmac_yaz_idx] <= yazmac_yaz_veri;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_xfer(input logic y, input logic [31:0] t, input logic [4:0] ilk,
                           input logic [3:0] n, output int nwr, output int lat,
                           output int busy, output logic h, output logic [31:0] adr);
      bit ilk_yaz;
      @(negedge clk);
      baslat = 1'b1; yon = y; taban_adres = t; ilk_yazmac = ilk; sayi = n;
      @(posedge clk);
      #1 baslat = 1'b0;
      nwr = 0; lat = -1; busy = 0; h = 1'b0; adr = 32'hFFFF_FFFF; ilk_yaz = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bellek_yaz || yazmac_yaz) begin
            if (ilk_yaz) adr = bellek_adres;
            ilk_yaz = 1'b0;
            nwr++;
         end
         if (mesgul) busy++;
         if (bitti) begin
            lat = c;
            h = hata;
            break;
         end
      end
   endtask

   typedef struct {
      string       name;
      logic        yon;
      logic [31:0] taban;
      logic [4:0]  ilk;
      logic [3:0]  sayi;
      int          nwr;
      int          lat;
      int          busy;
      logic        hata;
      logic [31:0] adr;
   } vec_t;

   vec_t vt [6];

   initial begin
      int nwr, lat, busy, nb, b1, b2;
      logic h;
      logic [31:0] adr;

      vt[0] = '{"load",   1'b0, 32'h8000_0030, 5'd16, 4'd4,  4, 5, 4, 1'b0, 32'h8000_0030};
      vt[1] = '{"store",  1'b1, 32'h8000_0030, 5'd5,  4'd5,  5, 6, 5, 1'b0, 32'h8000_0030};
      vt[2] = '{"zero",   1'b1, 32'h8000_0060, 5'd5,  4'd0,  0, 1, 0, 1'b0, 32'hFFFF_FFFF};
      vt[3] = '{"clamp",  1'b1, 32'h8000_0080, 5'd16, 4'd15, 8, 9, 8, 1'b0, 32'h8000_0080};
      vt[4] = '{"wrap",   1'b0, 32'h8000_0030, 5'd30, 4'd4,  3, 5, 4, 1'b0, 32'h8000_0030};
`ifdef TOPLU_AKTARIM_HIZA_KONTROL_EN
      vt[5] = '{"align",  1'b1, 32'h8000_0032, 5'd20, 4'd2,  0, 1, 0, 1'b1, 32'hFFFF_FFFF};
`else
      vt[5] = '{"align",  1'b1, 32'h8000_0032, 5'd20, 4'd2,  2, 3, 2, 1'b0, 32'h8000_0030};
`endif

      repeat (3) @(posedge clk);
      #1;
      check("rst_mesgul", 32'(mesgul), 0);
      check("rst_bitti", 32'(bitti), 0);
      check("rst_hata", 32'(hata), 0);
      check("rst_wr", {30'd0, bellek_yaz, yazmac_yaz}, 0);
      check("rst_adres", bellek_adres, 0);
      @(negedge clk);
      yukle = 1'b0;
      rst = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_xfer(vt[i].yon, vt[i].taban, vt[i].ilk, vt[i].sayi, nwr, lat, busy, h, adr);
         check({vt[i].name, "_writes"}, nwr, vt[i].nwr);
         check({vt[i].name, "_latency"}, lat, vt[i].lat);
         check({vt[i].name, "_busy"}, busy, vt[i].busy);
         check({vt[i].name, "_hata"}, 32'(h), 32'(vt[i].hata));
         check({vt[i].name, "_addr"}, adr, vt[i].adr);
         case (i)
            0: begin
               check("load_x16", rf[16], 5);  check("load_x17", rf[17], 10);
               check("load_x18", rf[18], 15); check("load_x19", rf[19], 25);
               check("load_x15", rf[15], 0);  check("load_x20", rf[20], 32'h114);
            end
            1: begin
               check("store_m0", mem[12], 5);  check("store_m1", mem[13], 10);
               check("store_m2", mem[14], 15); check("store_m3", mem[15], 12);
               check("store_m4", mem[16], 11); check("store_m5", mem[17], 0);
            end
            3: begin
               check("clamp_m0", mem[32], 5);      check("clamp_m3", mem[35], 25);
               check("clamp_m4", mem[36], 32'h114); check("clamp_m7", mem[39], 32'h117);
               check("clamp_m8", mem[40], 32'hDEAD);
            end
            4: begin
               check("wrap_x30", rf[30], 5); check("wrap_x31", rf[31], 10);
               check("wrap_x0", rf[0], 0);   check("wrap_x1", rf[1], 12);
               check("wrap_x2", rf[2], 0);
            end
            5: begin
`ifdef TOPLU_AKTARIM_HIZA_KONTROL_EN
               check("align_m0", mem[12], 5); check("align_m1", mem[13], 10);
`else
               check("align_m0", mem[12], 32'h114); check("align_m1", mem[13], 32'h115);
               check("align_m2", mem[14], 15);
`endif
            end
            default: ;
         endcase
      end

      // Reset after two words of an eight-word store.
      @(negedge clk);
      baslat = 1'b1; yon = 1'b1; taban_adres = 32'h8000_00C0; ilk_yazmac = 5'd20; sayi = 4'd8;
      @(posedge clk);
      #1 baslat = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_mesgul", 32'(mesgul), 0);
      check("mid_rst_bwr", 32'(bellek_yaz), 0);
      check("mid_rst_adres", bellek_adres, 0);
      check("mid_rst_veri", bellek_yaz_veri, 0);
      nb = 0;
      repeat (3) begin
         @(negedge clk);
         if (bitti) nb++;
      end
      rst = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (bitti) nb++;
      end
      check("mid_rst_nobitti", nb, 0);
      check("mid_rst_m0", mem[48], 32'h114);
      check("mid_rst_m1", mem[49], 32'h115);
      check("mid_rst_m2", mem[50], 0);
      run_xfer(1'b1, 32'h8000_00C8, 5'd5, 4'd1, nwr, lat, busy, h, adr);
      check("post_rst_writes", nwr, 1);
      check("post_rst_latency", lat, 2);
      check("post_rst_m2", mem[50], 5);

      // baslat held for ten edges: exactly two three-word transfers.
      @(negedge clk);
      baslat = 1'b1; yon = 1'b1; taban_adres = 32'h8000_00E0; ilk_yazmac = 5'd5; sayi = 4'd3;
      nb = 0; nwr = 0; b1 = -1; b2 = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 10) baslat = 1'b0;
         if (bellek_yaz) nwr++;
         if (bitti) begin
            nb++;
            if (b1 < 0) b1 = c;
            else if (b2 < 0) b2 = c;
         end
      end
      check("b2b_bitti_count", nb, 2);
      check("b2b_bitti1", b1, 4);
      check("b2b_bitti2", b2, 9);
      check("b2b_writes", nwr, 6);
      check("b2b_m0", mem[56], 5);
      check("b2b_m2", mem[58], 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
